// File: rtl/spi_ram_slave_param.sv
// SPI-style slave with an internal RAM: one frame sets an address or moves one
// word, with independent write and read address pointers.
module spi_ram_slave_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHK_CMD  = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    RD_WAIT  = 3'd4,
    RD_SHIFT = 3'd5
  } state_t;

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W);

  state_t              state, state_nx;
  logic [FRAME_W-2:0]  in_sh;
  logic [FRAME_W-1:0]  frame_nx;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   out_sh;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic                last_in, last_out;
  logic                ld_wr, do_wr, ld_rd, do_rd, bad;

  // The bit sampled on the completion edge is still on MOSI, so the decoded
  // frame is the history register plus the live input.
  assign frame_nx = {in_sh, MOSI};
  assign cmd      = frame_nx[FRAME_W-1 -: 2];
  assign payload  = frame_nx[DATA_W-1:0];
  assign last_in  = (cnt == CNT_W'(FRAME_W - 1));
  assign last_out = (cnt == CNT_W'(DATA_W - 1));

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nx = state;
    ld_wr    = 1'b0;
    do_wr    = 1'b0;
    ld_rd    = 1'b0;
    do_rd    = 1'b0;
    bad      = 1'b0;
    case (state)
      IDLE:     if (!SS_n) state_nx = CHK_CMD;
      CHK_CMD:  state_nx = MOSI ? READ : WRITE;
      WRITE: if (last_in) begin
        state_nx = IDLE;
        ld_wr    = (cmd == 2'b00);
        do_wr    = (cmd == 2'b01);
        bad      = cmd[1];
      end
      READ: if (last_in) begin
        state_nx = (cmd == 2'b11) ? RD_WAIT : IDLE;
        ld_rd    = (cmd == 2'b10);
        do_rd    = (cmd == 2'b11);
        bad      = !cmd[1];
      end
      RD_WAIT:  state_nx = RD_SHIFT;
      RD_SHIFT: if (last_out) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    // Deselect wins over everything, including a completing frame.
    if (state != IDLE && SS_n) begin
      state_nx = IDLE;
      ld_wr    = 1'b0;
      do_wr    = 1'b0;
      ld_rd    = 1'b0;
      do_rd    = 1'b0;
      bad      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      in_sh   <= '0;
      out_sh  <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      MISO    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx == state) ? cnt + CNT_W'(1) : '0;
      in_sh <= (state == WRITE || state == READ) ? frame_nx[FRAME_W-2:0] : '0;
      err   <= bad;
      MISO  <= (state_nx == RD_SHIFT) ? out_sh[DATA_W-1] : 1'b0;

      if (do_rd)                      out_sh <= mem[rd_addr];
      else if (state_nx == RD_SHIFT)  out_sh <= out_sh << 1;

      if (ld_wr)                         wr_addr <= payload[ADDR_W-1:0];
      else if (do_wr && AUTO_INC != 0)   wr_addr <= addr_inc(wr_addr);

      if (ld_rd)                         rd_addr <= payload[ADDR_W-1:0];
      else if (do_rd && AUTO_INC != 0)   rd_addr <= addr_inc(rd_addr);
    end
  end

  // NOTE: the RAM array has no reset so contents survive rst and the array
  // maps onto plain memory macros.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_addr] <= payload;
  end

endmodule

// File: tb/tb_spi_ram_slave_param.sv
// Bench for spi_ram_slave_param: three configurations (defaults, 16/10/1024,
// AUTO_INC=0) driven from one frame table plus hand-written corner sequences.
module tb_spi_ram_slave_param;

  typedef struct {
    int          k;
    logic        sel;
    logic [1:0]  cmd;
    logic [15:0] pl;
    logic        rd;
    logic        exp_err;
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
    int          maddr;
    logic [15:0] mdata;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ss_n, mosi, miso, err;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  spi_ram_slave_param u0 (
    .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]), .err(err[0])
  );
  spi_ram_slave_param #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024), .AUTO_INC(1)) u1 (
    .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]), .err(err[1])
  );
  spi_ram_slave_param #(.AUTO_INC(0)) u2 (
    .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2]), .err(err[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int dw_of(input int k);
    return (k == 1) ? 16 : 8;
  endfunction

  function automatic logic [31:0] get_wr(input int k);
    case (k)
      0:       return 32'(u0.wr_addr);
      1:       return 32'(u1.wr_addr);
      default: return 32'(u2.wr_addr);
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int k);
    case (k)
      0:       return 32'(u0.rd_addr);
      1:       return 32'(u1.rd_addr);
      default: return 32'(u2.rd_addr);
    endcase
  endfunction

  function automatic logic [31:0] get_state(input int k);
    case (k)
      0:       return 32'(u0.state);
      1:       return 32'(u1.state);
      default: return 32'(u2.state);
    endcase
  endfunction

  function automatic logic [31:0] get_mem(input int k, input int a);
    case (k)
      0:       return 32'(u0.mem[a[7:0]]);
      1:       return 32'(u1.mem[a[9:0]]);
      default: return 32'(u2.mem[a[7:0]]);
    endcase
  endfunction

  // Starts on a negedge with the slave in IDLE; returns on the negedge after the
  // completion edge (or after the abort edge when nbits < payload width).
  task automatic send_frame(input int k, input logic sel, input logic [1:0] cmd,
                            input logic [15:0] pl, input int nbits, input logic hold);
    int dw;
    dw = dw_of(k);
    ss_n[k] = 1'b0;
    mosi[k] = 1'b0;
    @(negedge clk) mosi[k] = sel;
    for (int i = 1; i >= 0; i--) begin
      @(negedge clk) mosi[k] = cmd[i];
    end
    for (int i = dw - 1; i >= dw - nbits; i--) begin
      @(negedge clk) mosi[k] = pl[i];
    end
    @(negedge clk);
    if (nbits < dw) begin
      ss_n[k] = 1'b1;
      @(negedge clk);
    end else if (!hold) begin
      ss_n[k] = 1'b1;
    end
  endtask

  // Called in RD_WAIT; compares nb MISO bits against the scoreboard queue.
  task automatic read_out(input int k, input int nb);
    logic e;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check($sformatf("u%0d_miso_bit%0d", k, i), 32'(miso[k]), 32'(e));
    end
    if (nb == dw_of(k)) begin
      @(negedge clk);
      check($sformatf("u%0d_miso_idle", k), 32'(miso[k]), 32'h0);
      check($sformatf("u%0d_state_after_read", k), get_state(k), 32'h0);
      ss_n[k] = 1'b1;
    end
  endtask

  task automatic add(input int k, input logic sel, input logic [1:0] cmd, input logic [15:0] pl,
                     input logic rd, input logic e, input logic [15:0] w, input logic [15:0] r,
                     input int ma, input logic [15:0] md);
    vec_t v;
    v.k = k; v.sel = sel; v.cmd = cmd; v.pl = pl; v.rd = rd; v.exp_err = e;
    v.exp_wr = w; v.exp_rd = r; v.maddr = ma; v.mdata = md;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //  k  sel   cmd    payload   rd    err   wr_addr  rd_addr  mem addr/data
    add(0, 1'b0, 2'b00, 16'h0012, 1'b0, 1'b0, 16'h012, 16'h000, -1,    16'h0000);
    add(0, 1'b0, 2'b01, 16'h00A5, 1'b0, 1'b0, 16'h013, 16'h000, 'h12, 16'h00A5);
    add(0, 1'b1, 2'b10, 16'h0012, 1'b0, 1'b0, 16'h013, 16'h012, -1,    16'h0000);
    add(0, 1'b1, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h013, 16'h013, 'h12, 16'h00A5);
    add(0, 1'b0, 2'b00, 16'h00FF, 1'b0, 1'b0, 16'h0FF, 16'h013, -1,    16'h0000);
    add(0, 1'b0, 2'b01, 16'h0011, 1'b0, 1'b0, 16'h000, 16'h013, 'hFF, 16'h0011);
    add(0, 1'b0, 2'b01, 16'h0022, 1'b0, 1'b0, 16'h001, 16'h013, 'h00, 16'h0022);
    add(0, 1'b0, 2'b11, 16'h0077, 1'b0, 1'b1, 16'h001, 16'h013, 'h00, 16'h0022);
    add(0, 1'b1, 2'b01, 16'h0033, 1'b0, 1'b1, 16'h001, 16'h013, 'h12, 16'h00A5);
    add(1, 1'b0, 2'b00, 16'h0012, 1'b0, 1'b0, 16'h012, 16'h000, -1,    16'h0000);
    add(1, 1'b0, 2'b01, 16'hA5A5, 1'b0, 1'b0, 16'h013, 16'h000, 'h12, 16'hA5A5);
    add(1, 1'b1, 2'b10, 16'h0012, 1'b0, 1'b0, 16'h013, 16'h012, -1,    16'h0000);
    add(1, 1'b1, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h013, 16'h013, 'h12, 16'hA5A5);
    add(1, 1'b0, 2'b00, 16'h03FF, 1'b0, 1'b0, 16'h3FF, 16'h013, -1,    16'h0000);
    add(1, 1'b0, 2'b01, 16'h1111, 1'b0, 1'b0, 16'h000, 16'h013, 'h3FF, 16'h1111);
    add(1, 1'b0, 2'b01, 16'h2222, 1'b0, 1'b0, 16'h001, 16'h013, 'h000, 16'h2222);
    add(2, 1'b0, 2'b00, 16'h0012, 1'b0, 1'b0, 16'h012, 16'h000, -1,    16'h0000);
    add(2, 1'b0, 2'b01, 16'h00A5, 1'b0, 1'b0, 16'h012, 16'h000, 'h12, 16'h00A5);
    add(2, 1'b1, 2'b10, 16'h0012, 1'b0, 1'b0, 16'h012, 16'h012, -1,    16'h0000);
    add(2, 1'b1, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h012, 16'h012, 'h12, 16'h00A5);
    add(2, 1'b0, 2'b00, 16'h00FF, 1'b0, 1'b0, 16'h0FF, 16'h012, -1,    16'h0000);
    add(2, 1'b0, 2'b01, 16'h0011, 1'b0, 1'b0, 16'h0FF, 16'h012, 'hFF, 16'h0011);
    add(2, 1'b0, 2'b01, 16'h0022, 1'b0, 1'b0, 16'h0FF, 16'h012, 'hFF, 16'h0022);

    rst  = 1'b1;
    ss_n = 3'b111;
    mosi = 3'b000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d_rst_state", k), get_state(k), 32'h0);
      check($sformatf("u%0d_rst_miso", k), 32'(miso[k]), 32'h0);
      check($sformatf("u%0d_rst_err", k), 32'(err[k]), 32'h0);
      check($sformatf("u%0d_rst_wr", k), get_wr(k), 32'h0);
      check($sformatf("u%0d_rst_rd", k), get_rd(k), 32'h0);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.rd) for (int b = dw_of(v.k) - 1; b >= 0; b--) exp_q.push_back(v.mdata[b]);
      send_frame(v.k, v.sel, v.cmd, v.pl, dw_of(v.k), v.rd);
      check($sformatf("row%0d_err", i), 32'(err[v.k]), 32'(v.exp_err));
      check($sformatf("row%0d_wr_addr", i), get_wr(v.k), 32'(v.exp_wr));
      check($sformatf("row%0d_rd_addr", i), get_rd(v.k), 32'(v.exp_rd));
      if (v.maddr >= 0)
        check($sformatf("row%0d_mem", i), get_mem(v.k, v.maddr), 32'(v.mdata));
      if (v.rd) begin
        read_out(v.k, dw_of(v.k));
      end else begin
        @(negedge clk);
        check($sformatf("row%0d_err_drop", i), 32'(err[v.k]), 32'h0);
      end
    end

    // Wrapped write left the top word intact.
    check("u0_mem_ff_kept", get_mem(0, 'hFF), 32'h11);

    // Deselect after 5 payload bits discards the frame.
    send_frame(0, 1'b0, 2'b00, 16'h0012, 8, 1'b0);
    check("abort_setup_wr", get_wr(0), 32'h12);
    send_frame(0, 1'b0, 2'b01, 16'h005A, 5, 1'b0);
    check("abort_state", get_state(0), 32'h0);
    check("abort_err", 32'(err[0]), 32'h0);
    check("abort_miso", 32'(miso[0]), 32'h0);
    check("abort_mem", get_mem(0, 'h12), 32'hA5);
    check("abort_wr", get_wr(0), 32'h12);
    @(negedge clk);
    check("abort_err_late", 32'(err[0]), 32'h0);
    send_frame(0, 1'b0, 2'b01, 16'h005A, 8, 1'b0);
    check("after_abort_mem", get_mem(0, 'h12), 32'h5A);
    check("after_abort_wr", get_wr(0), 32'h13);
    check("after_abort_err", 32'(err[0]), 32'h0);

    // Back-to-back frames with select held low.
    send_frame(0, 1'b0, 2'b00, 16'h0040, 8, 1'b1);
    send_frame(0, 1'b0, 2'b01, 16'h003C, 8, 1'b0);
    check("b2b_mem", get_mem(0, 'h40), 32'h3C);
    check("b2b_wr", get_wr(0), 32'h41);

    // Reset during the third RD_SHIFT cycle.
    send_frame(0, 1'b1, 2'b10, 16'h0040, 8, 1'b0);
    check("rst_rd_setup", get_rd(0), 32'h40);
    for (int b = 7; b >= 0; b--) exp_q.push_back(8'h3C >> b);
    send_frame(0, 1'b1, 2'b11, 16'h0000, 8, 1'b1);
    read_out(0, 3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_shift_miso", 32'(miso[0]), 32'h0);
    check("rst_shift_state", get_state(0), 32'h0);
    check("rst_shift_wr", get_wr(0), 32'h0);
    check("rst_shift_rd", get_rd(0), 32'h0);
    rst     = 1'b0;
    ss_n[0] = 1'b1;
    exp_q.delete();
    check("rst_ram_40", get_mem(0, 'h40), 32'h3C);
    check("rst_ram_12", get_mem(0, 'h12), 32'h5A);
    @(negedge clk);
    check("post_rst_state", get_state(0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
